// File: rtl/orb_bank_ctrl_pkg.sv
// orb_bank_pkg: shared types and defaults for the Orbita frame-buffer
// ping-pong bank controller.
//   state_e   - controller FSM states
//   BANK0/1   - bank index constants (also the rd_sel encoding)
//   *_DEF     - default widths / read latency
package orb_bank_pkg;

  typedef enum logic [1:0] {
    ST_WAIT      = 2'd0,  // writer filling wr_bank
    ST_HELD      = 2'd1,  // wr_bank holds a complete frame, waiting for swap
    ST_DROP      = 2'd2,  // incoming frame discarded, no swap seen yet
    ST_DROP_FREE = 2'd3   // swapped, but tail of the discarded frame still masked
  } state_e;

  localparam logic BANK0 = 1'b0;
  localparam logic BANK1 = 1'b1;

  localparam int ADDR_W_DEF = 11;
  localparam int CNT_W_DEF  = 8;
  localparam int RD_LAT_DEF = 2;

endpackage

// File: rtl/orb_bank_ctrl_if.sv
// orb_bank_ctrl_if: packer/reader/RAM-side signals of the bank controller.
//   master - packer + reader + RAM side (drives strobes, observes RAM ports)
//   slave  - the controller itself
interface orb_bank_ctrl_if
  import orb_bank_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);
  // packer side
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_frame_done;
  // reader side
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_frame_start;
  // RAM bank ports
  logic              ram0_wren,   ram1_wren;
  logic [ADDR_W-1:0] ram0_wraddr, ram1_wraddr;
  logic              ram0_rden,   ram1_rden;
  logic [ADDR_W-1:0] ram0_rdaddr, ram1_rdaddr;
  // status
  logic              rd_sel;
  logic              wr_bank;
  logic              frame_ready;
  logic [CNT_W-1:0]  overrun_cnt;
  logic [CNT_W-1:0]  underrun_cnt;

  modport master (
    output wr_en, wr_addr, wr_frame_done, rd_en, rd_addr, rd_frame_start,
    input  ram0_wren, ram1_wren, ram0_wraddr, ram1_wraddr,
           ram0_rden, ram1_rden, ram0_rdaddr, ram1_rdaddr,
           rd_sel, wr_bank, frame_ready, overrun_cnt, underrun_cnt
  );

  modport slave (
    input  wr_en, wr_addr, wr_frame_done, rd_en, rd_addr, rd_frame_start,
    output ram0_wren, ram1_wren, ram0_wraddr, ram1_wraddr,
           ram0_rden, ram1_rden, ram0_rdaddr, ram1_rdaddr,
           rd_sel, wr_bank, frame_ready, overrun_cnt, underrun_cnt
  );
endinterface

// File: rtl/orb_bank_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones.
//   clk, rst_n - clock, async active-low reset (clears to 0)
//   inc_i      - count enable
//   cnt_o      - current count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/orb_bank_ctrl.sv
// orb_bank_ctrl: ping-pong controller for the two Orbita frame RAM banks.
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   bus  - packer strobes in, reader strobes in, per-bank RAM ports out
//          (registered), rd_sel q-mux select, wr_bank, frame_ready and
//          saturating overrun/underrun counters.
// Writer and reader always target opposite banks; banks swap only on a
// reader frame start while a complete frame is waiting.
module orb_bank_ctrl
  import orb_bank_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  orb_bank_ctrl_if.slave bus
);

  state_e state_q, state_d;
  logic   rd_bank_q;
  logic   swap, mask, ovr_inc, und_inc;
  logic   rd_bank_eff, wr_bank_eff, wr_go;
  logic [1:0] wsel, rsel;

  logic [1:0]             wren_q, rden_q;
  logic [1:0][ADDR_W-1:0] wraddr_q, rdaddr_q;
  logic [RD_LAT-1:0]      sel_pipe_q;

  // Next state / event decode. Priority inside each state resolves the
  // simultaneous-pulse cases: a reader frame start always wins the swap.
  always_comb begin
    state_d = state_q;
    swap    = 1'b0;
    mask    = 1'b0;
    ovr_inc = 1'b0;
    und_inc = 1'b0;
    unique case (state_q)
      ST_WAIT: begin
        if (bus.wr_frame_done && bus.rd_frame_start) swap = 1'b1;
        else if (bus.wr_frame_done)                  state_d = ST_HELD;
        else if (bus.rd_frame_start)                 und_inc = 1'b1;
      end
      ST_HELD: begin
        if (bus.rd_frame_start) begin
          swap    = 1'b1;
          state_d = ST_WAIT;
        end else if (bus.wr_frame_done) begin
          // a frame finished while one is still held: it is lost
          ovr_inc = 1'b1;
          mask    = 1'b1;
        end else if (bus.wr_en) begin
          mask    = 1'b1;
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        mask = 1'b1;
        if (bus.wr_frame_done && bus.rd_frame_start) begin
          ovr_inc = 1'b1;
          swap    = 1'b1;
          state_d = ST_WAIT;
        end else if (bus.wr_frame_done) begin
          ovr_inc = 1'b1;
          state_d = ST_HELD;
        end else if (bus.rd_frame_start) begin
          swap    = 1'b1;
          state_d = ST_DROP_FREE;
        end
      end
      ST_DROP_FREE: begin
        mask = 1'b1;
        if (bus.wr_frame_done) begin
          ovr_inc = 1'b1;
          state_d = ST_WAIT;
        end
        // nothing new was captured, so the reader repeats its frame
        if (bus.rd_frame_start) und_inc = 1'b1;
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // Steering uses the post-swap banks of this cycle so the first beat
  // after a swap already lands in the new bank.
  assign rd_bank_eff = rd_bank_q ^ swap;
  assign wr_bank_eff = ~rd_bank_eff;
  assign wr_go       = bus.wr_en & ~mask;
  assign wsel        = wr_go      ? ((wr_bank_eff == BANK1) ? 2'b10 : 2'b01) : 2'b00;
  assign rsel        = bus.rd_en  ? ((rd_bank_eff == BANK1) ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_WAIT;
      rd_bank_q  <= BANK0;
      wren_q     <= '0;
      rden_q     <= '0;
      wraddr_q   <= '0;
      rdaddr_q   <= '0;
      sel_pipe_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_bank_q <= rd_bank_eff;
      wren_q    <= wsel;
      rden_q    <= rsel;
      for (int b = 0; b < 2; b++) begin
        if (wsel[b]) wraddr_q[b] <= bus.wr_addr;
        if (rsel[b]) rdaddr_q[b] <= bus.rd_addr;
      end
      // rd_sel follows the bank each read was issued to, RD_LAT cycles
      // later, so q from the old bank is still muxed correctly after a swap
      sel_pipe_q[0] <= rd_bank_eff;
      for (int i = 1; i < RD_LAT; i++) sel_pipe_q[i] <= sel_pipe_q[i-1];
    end
  end

  sat_counter #(.W(CNT_W)) u_ovr_cnt (
    .clk  (clk),
    .rst_n(rst),
    .inc_i(ovr_inc),
    .cnt_o(bus.overrun_cnt)
  );

  sat_counter #(.W(CNT_W)) u_und_cnt (
    .clk  (clk),
    .rst_n(rst),
    .inc_i(und_inc),
    .cnt_o(bus.underrun_cnt)
  );

  assign bus.ram0_wren   = wren_q[0];
  assign bus.ram1_wren   = wren_q[1];
  assign bus.ram0_wraddr = wraddr_q[0];
  assign bus.ram1_wraddr = wraddr_q[1];
  assign bus.ram0_rden   = rden_q[0];
  assign bus.ram1_rden   = rden_q[1];
  assign bus.ram0_rdaddr = rdaddr_q[0];
  assign bus.ram1_rdaddr = rdaddr_q[1];
  assign bus.rd_sel      = sel_pipe_q[RD_LAT-1];
  assign bus.wr_bank     = ~rd_bank_q;
  assign bus.frame_ready = (state_q == ST_HELD) || (state_q == ST_DROP);

endmodule

// File: doc/orb_bank_ctrl.md
# orb_bank_ctrl

Ping-pong bank controller for the Orbita frame buffer. Sits between the frame packer (writer, UART-fed) and the M16 frame reader, and owns the two frame RAM banks. It steers writes and reads to opposite banks, swaps them only on reader frame boundaries when a complete frame is waiting, and drops or repeats frames on overrun or underrun. Everything runs in one clock domain; RAM port signals are registered.

## Interface
- ADDR_W, 11, word address width of each bank
- CNT_W, 8, width of the saturating drop/repeat counters
- RD_LAT, 2, cycles from rd_en to valid RAM q, including this block's output register

Ports:
- clk  in  1  system clock, 80 MHz
- rst  in  1  asynchronous, active-low reset
- wr_en  in  1  packer write strobe
- wr_addr  in  ADDR_W  packer write address
- wr_frame_done  in  1  one-cycle pulse: packer finished a frame
- rd_en  in  1  reader read strobe
- rd_addr  in  ADDR_W  reader address, already incremented by the reader
- rd_frame_start  in  1  one-cycle pulse: reader begins a new frame
- ram0_wren, ram1_wren  out  1  per-bank write enable
- ram0_wraddr, ram1_wraddr  out  ADDR_W  per-bank write address
- ram0_rden, ram1_rden  out  1  per-bank read enable
- ram0_rdaddr, ram1_rdaddr  out  ADDR_W  per-bank read address
- rd_sel  out  1  q mux select (0 = bank0), aligned to RAM data
- wr_bank  out  1  current write bank
- frame_ready  out  1  complete frame held, awaiting swap
- overrun_cnt  out  CNT_W  frames dropped, saturating
- underrun_cnt  out  CNT_W  frames repeated, saturating

## Operation
- Registers: rd_bank, wr_bank = ~rd_bank, and a 4-state FSM.
- WAIT: the writer fills wr_bank.
  - wr_frame_done goes to HELD.
  - rd_frame_start alone increments underrun_cnt; rd_bank does not swap and the reader repeats its frame.
- HELD: wr_bank holds a complete frame.
  - rd_frame_start swaps both banks and goes to WAIT.
  - wr_en without rd_frame_start masks the write and goes to DROP.
  - wr_frame_done without writes increments overrun_cnt and stays in HELD.
- DROP: the incoming frame is discarded and writes are masked.
  - wr_frame_done increments overrun_cnt and goes to HELD.
  - rd_frame_start swaps and goes to DROP_FREE.
- DROP_FREE: after a swap, the rest of the partial frame is still discarded and writes stay masked.
  - wr_frame_done increments overrun_cnt and goes to WAIT.
  - rd_frame_start increments underrun_cnt.
- Simultaneous events:
  - In HELD, rd_frame_start together with wr_en: the swap wins, the write goes to the new wr_bank unmasked, next state WAIT.
  - In WAIT, wr_frame_done together with rd_frame_start: swap immediately, stay WAIT, no underrun.
  - In DROP, both pulses in the same cycle: overrun_cnt++ and swap, next state WAIT.
- The bank decision in cycle t uses the post-swap bank values of cycle t, so a frame is never split across banks.
- frame_ready = (state == HELD or DROP).
- Counters saturate at 2^CNT_W−1 and never wrap.

## Timing
- All RAM port outputs are registered: 1-cycle latency from wr_en/rd_en to ramX_* signals.
- rd_sel is rd_bank delayed through an RD_LAT-deep shift register, so it stays valid with q across a swap.
- A swap takes effect on the cycle after the rd_frame_start sample.
- Reset, asynchronous, outputs forced immediately:
  - state WAIT, rd_bank 0, wr_bank 1;
  - all wren/rden 0, all addresses 0, rd_sel 0;
  - counters 0, frame_ready 0.
- Reset mid-frame discards all state. Until the first swap, the reader gets uninitialised bank0 data.

## Structure
- Package orb_bank_pkg: FSM state type (WAIT, HELD, DROP, DROP_FREE), bank index constants BANK0/BANK1, default ADDR_W/CNT_W.
- One sub-module: sat_counter (width parameter, inc, async active-low reset), instantiated twice.
- Port steering, FSM and rd_sel delay line live in orb_bank_ctrl.

## Test plan
- Reset then one frame: 2048 writes to addr 0..2047, wr_frame_done, rd_frame_start -> frame_ready 1 then 0; wr_bank 1→0; next read of addr 5 has ram1_rden=1, ram1_rdaddr=5; rd_sel=1 after RD_LAT.
- Underrun: three rd_frame_start pulses with no writes -> underrun_cnt=3, rd_bank stays 0, no RAM write ever.
- Overrun: two full frames before any rd_frame_start -> second frame's writes all masked (ram1_wren stays 0), overrun_cnt=1, state HELD; then rd_frame_start swaps.
- Drop across swap: in HELD, 100 writes, rd_frame_start, 100 more writes, wr_frame_done -> zero writes reach either bank, overrun_cnt=1, state WAIT.
- Simultaneous: in HELD, wr_en at addr 7 in the same cycle as rd_frame_start -> ram0_wren=1, ram0_wraddr=7 next cycle, no mask; WAIT with both pulses -> swap, underrun_cnt unchanged.
- Saturation and reset: 300 underruns -> underrun_cnt=255; assert rst mid-frame -> all outputs at reset values the same cycle.
